// File: rtl/rf_writeback_arbiter_if.sv
// Writeback bus between functional-unit result ports and the RF/scoreboard write arbiter.
// Optional perf-counter signals exist only when WBARB_PERF_COUNTERS_EN is defined.
interface rf_writeback_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 96
) ();
    logic                      enable;
    logic [NUM_REQ-1:0]        request;
    logic [NUM_REQ*ADDR_W-1:0] destination;
    logic [NUM_REQ*DATA_W-1:0] data;
    logic [NUM_REQ-1:0]        grant;
    logic                      rf_write_enable;
    logic [ADDR_W-1:0]         rf_write_address;
    logic [DATA_W-1:0]         rf_write_data;
    logic                      sb_clear_enable;
    logic [ADDR_W-1:0]         sb_clear_address;
    logic                      busy_c;
`ifdef WBARB_PERF_COUNTERS_EN
    logic [31:0]               grant_count;
    logic [31:0]               conflict_count;
`endif

    // Functional-unit side: raises requests, receives grants and sees the RF write.
    modport master (
        output enable, request, destination, data,
        input  grant, rf_write_enable, rf_write_address, rf_write_data,
        input  sb_clear_enable, sb_clear_address, busy_c
`ifdef WBARB_PERF_COUNTERS_EN
        , input grant_count, conflict_count
`endif
    );

    // Arbiter side.
    modport slave (
        input  enable, request, destination, data,
        output grant, rf_write_enable, rf_write_address, rf_write_data,
        output sb_clear_enable, sb_clear_address, busy_c
`ifdef WBARB_PERF_COUNTERS_EN
        , output grant_count, conflict_count
`endif
    );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// Round-robin arbiter sharing the single RF write port; each grant also clears the scoreboard busy bit.
// Define WBARB_PERF_COUNTERS_EN to add grant/conflict counters.
module rf_writeback_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 96
) (
    input  logic                 clk,
    input  logic                 rst,
    rf_writeback_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;

    logic [NUM_REQ-1:0] eligible;
    logic               found;
    int unsigned        idx;
    int unsigned        win;

    // A unit granted this cycle still holds its request; mask it so it is not granted twice.
    assign eligible = bus.request & ~grant_q;

    // Winner search from the pointer upward with wrap, then select its payload.
    always_comb begin
        ptr_d   = ptr_q;
        grant_d = '0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        found   = 1'b0;
        idx     = 0;
        win     = 0;
        if (bus.enable) begin
            for (int unsigned off = 0; off < NUM_REQ; off++) begin
                idx = (32'(ptr_q) + off) % NUM_REQ;
                for (int unsigned j = 0; j < NUM_REQ; j++) begin
                    if (!found && (j == idx) && eligible[j]) begin
                        found = 1'b1;
                        win   = j;
                    end
                end
            end
            if (found) begin
                we_d  = 1'b1;
                ptr_d = PTR_W'((win + 1) % NUM_REQ);
                for (int unsigned j = 0; j < NUM_REQ; j++) begin
                    if (j == win) begin
                        grant_d[j] = 1'b1;
                        addr_d     = bus.destination[j*ADDR_W +: ADDR_W];
                        data_d     = bus.data[j*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            grant_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign bus.grant            = grant_q;
    assign bus.rf_write_enable  = we_q;
    assign bus.rf_write_address = addr_q;
    assign bus.rf_write_data    = data_q;
    assign bus.sb_clear_enable  = we_q;
    assign bus.sb_clear_address = addr_q;
    assign bus.busy_c           = (|bus.request) | we_q;

`ifdef WBARB_PERF_COUNTERS_EN
    logic [31:0] grant_cnt_q, conflict_cnt_q;
    logic        conflict_c;

    assign conflict_c = bus.enable && ($countones(eligible) > 1);

    // Free-running counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (we_d)       grant_cnt_q    <= grant_cnt_q + 32'd1;
            if (conflict_c) conflict_cnt_q <= conflict_cnt_q + 32'd1;
        end
    end

    assign bus.grant_count    = grant_cnt_q;
    assign bus.conflict_count = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed, table-driven bench for rf_writeback_arbiter (4 units, 7b address, 96b data).
module tb_rf_writeback_arbiter;
    logic clk;
    logic rst;

    rf_writeback_arbiter_if #(.NUM_REQ(4), .ADDR_W(7), .DATA_W(96)) bus ();

    rf_writeback_arbiter #(.NUM_REQ(4), .ADDR_W(7), .DATA_W(96)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       en;
        logic [3:0] req;
        logic [3:0] grant;
        logic       busy;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [6:0]  dest_tab [4];
    logic [95:0] data_tab [4];
    logic [6:0]  last_addr;
    logic [95:0] last_data;
    vec_t        vecs [25];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected address/data follow the granted unit and hold otherwise.
    task automatic expect_out(input string name, input logic [3:0] g, input logic b);
        for (int k = 0; k < 4; k++) begin
            if (g[k]) begin
                last_addr = dest_tab[k];
                last_data = data_tab[k];
            end
        end
        check({name, " grant"},   96'(bus.grant), 96'(g));
        check({name, " rf_we"},   96'(bus.rf_write_enable), 96'(|g));
        check({name, " sb_en"},   96'(bus.sb_clear_enable), 96'(|g));
        check({name, " rf_addr"}, 96'(bus.rf_write_address), 96'(last_addr));
        check({name, " sb_addr"}, 96'(bus.sb_clear_address), 96'(last_addr));
        check({name, " rf_data"}, bus.rf_write_data, last_data);
        check({name, " busy"},    96'(bus.busy_c), 96'(b));
    endtask

    task automatic expect_reset(input string name);
        last_addr = '0;
        last_data = '0;
        check({name, " grant"},   96'(bus.grant), 96'(0));
        check({name, " rf_we"},   96'(bus.rf_write_enable), 96'(0));
        check({name, " sb_en"},   96'(bus.sb_clear_enable), 96'(0));
        check({name, " rf_addr"}, 96'(bus.rf_write_address), 96'(0));
        check({name, " sb_addr"}, 96'(bus.sb_clear_address), 96'(0));
        check({name, " rf_data"}, bus.rf_write_data, 96'(0));
    endtask

    task automatic step(input string name, input logic en, input logic [3:0] req,
                        input logic [3:0] g, input logic b);
        @(negedge clk);
        bus.enable  = en;
        bus.request = req;
        @(posedge clk);
        #1;
        expect_out(name, g, b);
    endtask

    initial begin
        dest_tab[0] = 7'h10; data_tab[0] = {32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
        dest_tab[1] = 7'h11; data_tab[1] = {32'hB000_0001, 32'hB000_0002, 32'hB000_0003};
        dest_tab[2] = 7'h05; data_tab[2] = {32'h0000_0001, 32'h0000_0002, 32'h0000_0003};
        dest_tab[3] = 7'h13; data_tab[3] = {32'hD000_0001, 32'hD000_0002, 32'hD000_0003};
        last_addr = '0;
        last_data = '0;

        vecs[0]  = '{1'b1, 4'b0100, 4'b0100, 1'b1};
        vecs[1]  = '{1'b1, 4'b0100, 4'b0000, 1'b1};
        vecs[2]  = '{1'b1, 4'b0000, 4'b0000, 1'b0};
        vecs[3]  = '{1'b1, 4'b1001, 4'b1000, 1'b1};
        vecs[4]  = '{1'b1, 4'b1001, 4'b0001, 1'b1};
        vecs[5]  = '{1'b1, 4'b0001, 4'b0000, 1'b1};
        vecs[6]  = '{1'b1, 4'b0000, 4'b0000, 1'b0};
        vecs[7]  = '{1'b0, 4'b0110, 4'b0000, 1'b1};
        vecs[8]  = '{1'b0, 4'b0110, 4'b0000, 1'b1};
        vecs[9]  = '{1'b0, 4'b0110, 4'b0000, 1'b1};
        vecs[10] = '{1'b1, 4'b0110, 4'b0010, 1'b1};
        vecs[11] = '{1'b1, 4'b0110, 4'b0100, 1'b1};
        vecs[12] = '{1'b1, 4'b0100, 4'b0000, 1'b1};
        vecs[13] = '{1'b1, 4'b1000, 4'b1000, 1'b1};
        vecs[14] = '{1'b1, 4'b1000, 4'b0000, 1'b1};
        vecs[15] = '{1'b1, 4'b0000, 4'b0000, 1'b0};
        vecs[16] = '{1'b1, 4'b1111, 4'b0001, 1'b1};
        vecs[17] = '{1'b1, 4'b1111, 4'b0010, 1'b1};
        vecs[18] = '{1'b1, 4'b1111, 4'b0100, 1'b1};
        vecs[19] = '{1'b1, 4'b1111, 4'b1000, 1'b1};
        vecs[20] = '{1'b1, 4'b1111, 4'b0001, 1'b1};
        vecs[21] = '{1'b1, 4'b1111, 4'b0010, 1'b1};
        vecs[22] = '{1'b1, 4'b1111, 4'b0100, 1'b1};
        vecs[23] = '{1'b1, 4'b1111, 4'b1000, 1'b1};
        vecs[24] = '{1'b1, 4'b0000, 4'b0000, 1'b0};

        rst             = 1'b1;
        bus.enable      = 1'b1;
        bus.request     = '0;
        bus.destination = {dest_tab[3], dest_tab[2], dest_tab[1], dest_tab[0]};
        bus.data        = {data_tab[3], data_tab[2], data_tab[1], data_tab[0]};

        #3 expect_reset("por");
        #17 rst = 1'b0;

        // Reset window 110..150 ns with two units already requesting.
        #90 rst = 1'b1;
        bus.request = 4'b0011;
        #10 expect_reset("rst_window_a");
        #20 expect_reset("rst_window_b");
        #10 rst = 1'b0;
        @(posedge clk);
        #1 expect_out("post_rst_u0", 4'b0001, 1'b1);
        step("post_rst_u1", 1'b1, 4'b0011, 4'b0010, 1'b1);
        step("post_rst_hold", 1'b1, 4'b0010, 4'b0000, 1'b1);
        step("post_rst_idle", 1'b1, 4'b0000, 4'b0000, 1'b0);

        for (int i = 0; i < 25; i++)
            step($sformatf("v%0d", i), vecs[i].en, vecs[i].req, vecs[i].grant, vecs[i].busy);

        // Reset landing mid-strobe: strobe dies at once, pointer restarts at 0.
        step("mid_u1", 1'b1, 4'b0010, 4'b0010, 1'b1);
        #2 rst = 1'b1;
        #1 expect_reset("mid_kill");
        @(negedge clk);
        bus.request = 4'b0110;
        rst = 1'b0;
        @(posedge clk);
        #1 expect_out("mid_regrant_u1", 4'b0010, 1'b1);
        step("mid_u2", 1'b1, 4'b0110, 4'b0100, 1'b1);
        step("mid_hold", 1'b1, 4'b0100, 4'b0000, 1'b1);
        step("mid_idle", 1'b1, 4'b0000, 4'b0000, 1'b0);

        // Eight back-to-back cycles with all units requesting from a clean reset.
        @(negedge clk);
        rst = 1'b1;
        #1 expect_reset("perf_rst");
`ifdef WBARB_PERF_COUNTERS_EN
        check("perf_rst grant_count",    96'(bus.grant_count), 96'(0));
        check("perf_rst conflict_count", 96'(bus.conflict_count), 96'(0));
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++)
            step($sformatf("all_%0d", k), 1'b1, 4'hF, 4'(1 << (k % 4)), 1'b1);
        step("all_drop", 1'b1, 4'b0000, 4'b0000, 1'b0);
`ifdef WBARB_PERF_COUNTERS_EN
        check("grant_count",    96'(bus.grant_count), 96'(8));
        check("conflict_count", 96'(bus.conflict_count), 96'(8));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("cnt_rst grant_count",    96'(bus.grant_count), 96'(0));
        check("cnt_rst conflict_count", 96'(bus.conflict_count), 96'(0));
        @(negedge clk);
        rst = 1'b0;
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
